// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: skid-buffer state encoding.
package pipeline_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_BUSY  = 2'b01,
    S_FULL  = 2'b10
  } skid_state_t;

endpackage : pipeline_pkg

// File: rtl/skid_buffer.sv
// skid_buffer: ready/valid pipeline stage with a registered i_ready.
// A main slot drives o_data; a skid slot catches the word that lands in the
// cycle the consumer stalls, so upstream never sees o_ready combinationally.
// Optional transfer counter: define SKID_BUFFER_COUNT_EN to add xfer_count.
module skid_buffer
  import pipeline_pkg::*;
#(
  parameter int unsigned  N           = 8,
  parameter logic [N-1:0] RESET_VALUE = '0,
  parameter int unsigned  COUNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [N-1:0]      i_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [N-1:0]      o_data
`ifdef SKID_BUFFER_COUNT_EN
  ,
  output logic [COUNT_W-1:0] xfer_count
`endif
);

  skid_state_t  state_q, state_d;
  logic [N-1:0] main_q, main_d;
  logic [N-1:0] skid_q, skid_d;
  logic         i_ready_q, i_ready_d;
  logic         in_fire;
  logic         out_fire;

  assign in_fire  = i_valid & i_ready_q;
  assign out_fire = o_valid & o_ready;

  assign i_ready = i_ready_q;
  assign o_valid = (state_q != S_EMPTY);
  assign o_data  = main_q;

  // Next-state and slot-load decode; i_ready follows the next state.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          state_d = S_BUSY;
          main_d  = i_data;
        end
      end
      S_BUSY: begin
        if (in_fire && out_fire) begin
          main_d = i_data;
        end else if (in_fire) begin
          state_d = S_FULL;
          skid_d  = i_data;
        end else if (out_fire) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        // i_ready is low here, so only the drain of the main slot can occur.
        if (out_fire) begin
          state_d = S_BUSY;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
    i_ready_d = (state_d != S_FULL);
  end

  // State, slot and ready registers; reset drops any in-flight word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_EMPTY;
      main_q    <= RESET_VALUE;
      skid_q    <= RESET_VALUE;
      i_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      i_ready_q <= i_ready_d;
    end
  end

`ifdef SKID_BUFFER_COUNT_EN
  logic [COUNT_W-1:0] count_q, count_d;

  assign xfer_count = count_q;

  // Completed output transfers, wrapping modulo 2^COUNT_W.
  always_comb begin
    count_d = count_q;
    if (out_fire) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  // Transfer counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
`else
  localparam int unsigned unused_count_w = COUNT_W;
`endif

endmodule : skid_buffer

// File: tb/tb_skid_buffer.sv
// Directed self-checking bench for skid_buffer.
module tb_skid_buffer;

`ifdef SKID_BUFFER_COUNT_EN
  localparam int unsigned CW = 4;
`else
  localparam int unsigned CW = 16;
`endif

  logic          clk;
  logic          rst;
  logic          i_valid;
  logic          i_ready;
  logic [7:0]    i_data;
  logic          o_valid;
  logic          o_ready;
  logic [7:0]    o_data;
`ifdef SKID_BUFFER_COUNT_EN
  logic [CW-1:0] xfer_count;
`endif

  int passed;
  int total;

  skid_buffer #(
    .N           (8),
    .RESET_VALUE (8'h00),
    .COUNT_W     (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data)
`ifdef SKID_BUFFER_COUNT_EN
    ,
    .xfer_count (xfer_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b1; i_data = 8'hAA; o_ready = 1'b1;
    step();
    step();
    total++;
    if (o_valid !== 1'b0) $display("FAIL reset_o_valid: got %b want 0", o_valid);
    else passed++;
    total++;
    if (i_ready !== 1'b1) $display("FAIL reset_i_ready: got %b want 1", i_ready);
    else passed++;
    total++;
    if (o_data !== 8'h00) $display("FAIL reset_o_data: got %h want 00", o_data);
    else passed++;
`ifdef SKID_BUFFER_COUNT_EN
    total++;
    if (xfer_count !== '0) $display("FAIL reset_count: got %0d want 0", xfer_count);
    else passed++;
`endif
    rst = 1'b0; i_valid = 1'b0;
    step();
    total++;
    if (o_valid !== 1'b0) $display("FAIL reset_idle_o_valid: got %b want 0", o_valid);
    else passed++;
  endtask

  task automatic test_single();
    i_valid = 1'b1; i_data = 8'h11; o_ready = 1'b1;
    step();
    i_valid = 1'b0;
    total++;
    if (o_valid !== 1'b1) $display("FAIL single_o_valid: got %b want 1", o_valid);
    else passed++;
    total++;
    if (o_data !== 8'h11) $display("FAIL single_o_data: got %h want 11", o_data);
    else passed++;
    step();
    total++;
    if (o_valid !== 1'b0) $display("FAIL single_drain_o_valid: got %b want 0", o_valid);
    else passed++;
    total++;
    if (i_ready !== 1'b1) $display("FAIL single_drain_i_ready: got %b want 1", i_ready);
    else passed++;
  endtask

  task automatic test_back_to_back();
    o_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      i_valid = 1'b1; i_data = 8'(i);
      step();
      total++;
      if (o_valid !== 1'b1 || o_data !== 8'(i))
        $display("FAIL stream_word_%0d: got v=%b d=%h want v=1 d=%h", i, o_valid, o_data, 8'(i));
      else passed++;
      total++;
      if (i_ready !== 1'b1) $display("FAIL stream_i_ready_%0d: got %b want 1", i, i_ready);
      else passed++;
    end
    i_valid = 1'b0;
    step();
    total++;
    if (o_valid !== 1'b0) $display("FAIL stream_end_o_valid: got %b want 0", o_valid);
    else passed++;
`ifdef SKID_BUFFER_COUNT_EN
    // 1 word from the single test plus 16 streamed, modulo 2^4.
    total++;
    if (xfer_count !== 4'd1) $display("FAIL stream_count: got %0d want 1", xfer_count);
    else passed++;
`endif
  endtask

  task automatic test_stall();
    i_valid = 1'b1; i_data = 8'h21; o_ready = 1'b1;
    step();
    i_data = 8'h22; o_ready = 1'b0;
    step();
    total++;
    if (i_ready !== 1'b0) $display("FAIL stall_i_ready: got %b want 0", i_ready);
    else passed++;
    total++;
    if (o_valid !== 1'b1 || o_data !== 8'h21)
      $display("FAIL stall_hold_a: got v=%b d=%h want v=1 d=21", o_valid, o_data);
    else passed++;
    i_data = 8'h23;
    step();
    step();
    total++;
    if (o_valid !== 1'b1 || o_data !== 8'h21)
      $display("FAIL stall_hold_b: got v=%b d=%h want v=1 d=21", o_valid, o_data);
    else passed++;
    total++;
    if (i_ready !== 1'b0) $display("FAIL stall_hold_i_ready: got %b want 0", i_ready);
    else passed++;
    o_ready = 1'b1;
    step();
    total++;
    if (o_valid !== 1'b1 || o_data !== 8'h22)
      $display("FAIL stall_release_22: got v=%b d=%h want v=1 d=22", o_valid, o_data);
    else passed++;
    total++;
    if (i_ready !== 1'b1) $display("FAIL stall_release_i_ready: got %b want 1", i_ready);
    else passed++;
    step();
    i_valid = 1'b0;
    total++;
    if (o_valid !== 1'b1 || o_data !== 8'h23)
      $display("FAIL stall_release_23: got v=%b d=%h want v=1 d=23", o_valid, o_data);
    else passed++;
    step();
    total++;
    if (o_valid !== 1'b0) $display("FAIL stall_drain_o_valid: got %b want 0", o_valid);
    else passed++;
  endtask

  task automatic test_reset_full();
    i_valid = 1'b1; i_data = 8'h31; o_ready = 1'b1;
    step();
    i_data = 8'h32; o_ready = 1'b0;
    step();
    i_valid = 1'b0;
    total++;
    if (i_ready !== 1'b0) $display("FAIL rfull_pre_i_ready: got %b want 0", i_ready);
    else passed++;
    rst = 1'b1; o_ready = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (o_valid !== 1'b0) $display("FAIL rfull_o_valid: got %b want 0", o_valid);
    else passed++;
    total++;
    if (i_ready !== 1'b1) $display("FAIL rfull_i_ready: got %b want 1", i_ready);
    else passed++;
    total++;
    if (o_data !== 8'h00) $display("FAIL rfull_o_data: got %h want 00", o_data);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (o_valid !== 1'b0) $display("FAIL rfull_stale_%0d: got o_valid=%b want 0", i, o_valid);
      else passed++;
    end
  endtask

`ifdef SKID_BUFFER_COUNT_EN
  task automatic test_count_wrap();
    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (xfer_count !== 4'd0) $display("FAIL wrap_start: got %0d want 0", xfer_count);
    else passed++;
    for (int i = 0; i < 17; i++) begin
      i_valid = 1'b1; i_data = 8'(8'h40 + i);
      step();
    end
    // 16 transfers completed so far (word 17 still in the main slot).
    total++;
    if (xfer_count !== 4'd0) $display("FAIL wrap_16: got %0d want 0", xfer_count);
    else passed++;
    i_valid = 1'b0;
    step();
    total++;
    if (xfer_count !== 4'd1) $display("FAIL wrap_17: got %0d want 1", xfer_count);
    else passed++;
  endtask
`endif

  initial begin
    passed = 0;
    total = 0;
    rst = 1'b1; i_valid = 1'b0; i_data = 8'h00; o_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_full();
`ifdef SKID_BUFFER_COUNT_EN
    test_count_wrap();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_skid_buffer
